stack_unit: RTL
===============

# stack_unit

Hardware operand stack that serves the controller's push, pop and top-of-stack (tos) commands for the stack-machine CPU. It sits beside the datapath, takes the datapath's write operand on push, and returns the top element on pop or tos through a registered read port. It tracks fill level, reports full and empty, and latches overflow and underflow errors until cleared.

## Interface
- DATA_W, 8, width of a stack element (matches the 8-bit datapath)
- DEPTH, 16, number of entries; power of two, minimum 2
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  push din onto the stack this cycle
- pop  in  1  remove the top element and return it on dout
- tos  in  1  return the top element on dout without removing it
- clr  in  1  synchronous clear: empties the stack and clears error flags
- din  in  DATA_W  operand to push
- dout  out  DATA_W  registered read data
- dout_valid  out  1  one-cycle pulse: dout was updated by this cycle's edge
- count  out  CNT_W  current number of entries, 0..DEPTH
- full  out  1  count == DEPTH (combinational from count)
- empty  out  1  count == 0 (combinational from count)
- overflow  out  1  sticky: a push was rejected because the stack was full
- underflow  out  1  sticky: a pop or tos was rejected because the stack was empty

## Operation
- Storage: DEPTH x DATA_W register array, write pointer sp = count; top element is mem[count-1].
- Command resolution per cycle, highest priority first:
  - clr: count <= 0, overflow <= 0, underflow <= 0, dout_valid <= 0; all other commands that cycle are ignored; array contents are don't-care.
  - push & pop (replace): requires !empty. dout <= mem[count-1], mem[count-1] <= din, count unchanged, dout_valid <= 1. tos is ignored. If empty: the command is treated as a plain push (mem[0] <= din, count <= 1), underflow <= 1, dout_valid <= 0.
  - push only (tos ignored): if !full, mem[count] <= din and count <= count+1; if full, no state change except overflow <= 1.
  - pop (tos ignored): if !empty, dout <= mem[count-1], count <= count-1, dout_valid <= 1; if empty, underflow <= 1, dout holds its value, dout_valid <= 0.
  - tos only: if !empty, dout <= mem[count-1], dout_valid <= 1; if empty, underflow <= 1, dout_valid <= 0.
  - no command: state holds, dout_valid <= 0.
- Flags are sticky: once set, they stay set until clr or reset; later successful operations do not clear them.
- A rejected command never modifies the array, count, or dout.
- count arithmetic is unsigned CNT_W bits and never wraps: full blocks increment and empty blocks decrement.

## Timing
- Reset (rst_n low, asynchronous): count = 0, dout = 0, dout_valid = 0, overflow = 0, underflow = 0; full = 0, empty = 1. Array contents are not reset.
- Reset asserted mid-operation aborts any command that cycle; the first command after rst_n deasserts is sampled at the next rising edge.
- Read latency is 1 cycle: a pop or tos sampled at edge N presents data on dout, with dout_valid high, after edge N and until edge N+1.
- dout holds its last value while dout_valid is low.
- Push-to-read: an element pushed at edge N is readable by a pop or tos sampled at edge N+1.
- Back-to-back pops every cycle are supported with no bubbles.
- full, empty and count reflect state after the last edge; commands are decided on the registered count, not on same-cycle inputs.

## Test plan
- Reset then fill: assert rst_n low, release, push 0x01..0x10 on 16 consecutive cycles -> count goes 1..16; full=1 after the 16th edge; overflow=0; empty=0 after the first edge.
- Overflow: with the stack full, push 0xAA -> count stays 16, overflow=1; then pop -> dout=0x10, dout_valid pulses, overflow still 1.
- Drain and underflow: pop 16 times from a full stack -> dout sequence 0x10..0x01, one per cycle with dout_valid high throughout; empty=1; a 17th pop -> underflow=1, dout stays 0x01, dout_valid=0.
- Replace and tos: push 0x11, push 0x22, then push & pop with din=0x33 -> dout=0x22, count=2; then tos -> dout=0x33, count=2; then pop -> 0x33, then pop -> 0x11.
- Priority and clr: push 0x44 with pop, tos and clr all high -> count=0, flags cleared, dout_valid=0; tos on an empty stack -> underflow=1.
- Async reset mid-stream: assert rst_n low between clock edges during a pop burst -> outputs go to reset values immediately, without waiting for clk; the stack reads empty after release.

Source files
------------

// File: rtl/stack_unit_if.sv
// Command/read bus between the stack-machine controller and the operand stack.
interface stack_unit_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 5
);
   logic              push;
   logic              pop;
   logic              tos;
   logic              clr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              overflow;
   logic              underflow;

   modport master (
      output push, pop, tos, clr, din,
      input  dout, dout_valid, count, full, empty, overflow, underflow
   );

   modport slave (
      input  push, pop, tos, clr, din,
      output dout, dout_valid, count, full, empty, overflow, underflow
   );
endinterface

// File: rtl/stack_unit.sv
// Operand stack for the stack-machine CPU: push/pop/tos/replace with a
// registered read port, occupancy count and sticky overflow/underflow flags.
module stack_unit #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   stack_unit_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_dout;
   logic              r_valid;
   logic              r_ovf;
   logic              r_udf;

   logic [CNT_W-1:0]  w_count_nxt;
   logic [DATA_W-1:0] w_dout_nxt;
   logic              w_valid_nxt;
   logic              w_ovf_nxt;
   logic              w_udf_nxt;
   logic              w_we;
   logic [AW-1:0]     w_waddr;
   logic [AW-1:0]     w_slot;
   logic [AW-1:0]     w_top;
   logic [CNT_W-1:0]  w_count_m1;
   logic              w_full;
   logic              w_empty;

   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_empty    = (r_count == '0);
   // Free slot is only used when not full, so the low bits of count suffice.
   assign w_slot     = r_count[AW-1:0];
   // Top index wraps when empty, but it is never used in that case.
   assign w_count_m1 = r_count - CNT_W'(1);
   assign w_top      = w_count_m1[AW-1:0];

   // Command decode in priority order: clr, replace, push, pop, tos.
   always_comb begin
      w_count_nxt = r_count;
      w_dout_nxt  = r_dout;
      w_valid_nxt = 1'b0;
      w_ovf_nxt   = r_ovf;
      w_udf_nxt   = r_udf;
      w_we        = 1'b0;
      w_waddr     = w_slot;
      if (bus.clr) begin
         w_count_nxt = '0;
         w_ovf_nxt   = 1'b0;
         w_udf_nxt   = 1'b0;
      end else if (bus.push && bus.pop) begin
         if (!w_empty) begin
            w_dout_nxt  = r_mem[w_top];
            w_we        = 1'b1;
            w_waddr     = w_top;
            w_valid_nxt = 1'b1;
         end else begin
            // Replace on an empty stack degrades to a push into slot 0.
            w_we        = 1'b1;
            w_waddr     = w_slot;
            w_count_nxt = CNT_W'(1);
            w_udf_nxt   = 1'b1;
         end
      end else if (bus.push) begin
         if (!w_full) begin
            w_we        = 1'b1;
            w_count_nxt = r_count + CNT_W'(1);
         end else begin
            w_ovf_nxt   = 1'b1;
         end
      end else if (bus.pop) begin
         if (!w_empty) begin
            w_dout_nxt  = r_mem[w_top];
            w_count_nxt = w_count_m1;
            w_valid_nxt = 1'b1;
         end else begin
            w_udf_nxt   = 1'b1;
         end
      end else if (bus.tos) begin
         if (!w_empty) begin
            w_dout_nxt  = r_mem[w_top];
            w_valid_nxt = 1'b1;
         end else begin
            w_udf_nxt   = 1'b1;
         end
      end
   end

   // Control and read-port registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_dout  <= w_dout_nxt;
         r_valid <= w_valid_nxt;
         r_ovf   <= w_ovf_nxt;
         r_udf   <= w_udf_nxt;
      end
   end

   // Storage array; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= bus.din;
      end
   end

   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_valid;
   assign bus.count      = r_count;
   assign bus.full       = w_full;
   assign bus.empty      = w_empty;
   assign bus.overflow   = r_ovf;
   assign bus.underflow  = r_udf;
endmodule
